// File: rtl/uart_frame_parser.sv
// uart_frame_parser: extracts checksummed command frames from a UART byte stream
//
// Frame: HDR0 HDR1 CMD LEN PAYLOAD[LEN] CHK, CHK = (CMD + LEN + payload) mod 256.
// Ports:
//   sys_clk      system clock
//   sys_rst_n    asynchronous active-low reset
//   uart_done    byte-ready level from UART rx (one byte per rising edge)
//   uart_data    received byte, valid while uart_done is high
//   rd_addr      payload buffer read address
//   rd_data      payload byte at rd_addr, registered (1-cycle latency)
//   frame_valid  1-cycle pulse on a good frame
//   frame_cmd    CMD of the last good frame
//   frame_len    LEN of the last good frame
//   busy         high whenever a frame is in progress
//   err_chk      1-cycle pulse on checksum mismatch
//   err_len      1-cycle pulse on LEN > MAX_LEN
//   err_timeout  1-cycle pulse on inter-byte timeout
module uart_frame_parser #(
    parameter int         CLK_FREQ   = 50000000,
    parameter int         TIMEOUT_US = 2000,
    parameter int         MAX_LEN    = 16,
    parameter int         ADDR_W     = 4,
    parameter logic [7:0] HDR0       = 8'h55,
    parameter logic [7:0] HDR1       = 8'hAA
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              uart_done,
    input  logic [7:0]        uart_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              frame_valid,
    output logic [7:0]        frame_cmd,
    output logic [ADDR_W:0]   frame_len,
    output logic              busy,
    output logic              err_chk,
    output logic              err_len,
    output logic              err_timeout
);
    localparam int TO_CYC = CLK_FREQ / 1000000 * TIMEOUT_US;
    localparam int CW     = $clog2(TO_CYC + 1);

    typedef enum logic [2:0] {IDLE, WAIT_H1, CMD, LEN, PAYLOAD, CHK} state_t;

    state_t            state, nxt;
    logic              uart_done_d;
    logic              byte_stb;
    logic [7:0]        sum;
    logic [7:0]        cmd_r;
    logic [ADDR_W:0]   len;
    logic [ADDR_W-1:0] idx;
    logic [CW-1:0]     cnt;
    logic [7:0]        mem [0:MAX_LEN-1];
    logic              expire, len_bad, last;
    logic              good, bad_chk, bad_len, tmo, wr;

    assign byte_stb = uart_done & ~uart_done_d;
    assign expire   = (state != IDLE) && (cnt == CW'(TO_CYC));
    assign len_bad  = 32'(uart_data) > MAX_LEN;
    assign last     = {1'b0, idx} == len - 1'b1;
    assign busy     = state != IDLE;

    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) state <= IDLE;
        else            state <= nxt;

    // A byte arriving on the expiry cycle takes priority over the timeout.
    always_comb begin
        nxt = state;
        if (byte_stb) begin
            case (state)
                IDLE:    nxt = (uart_data == HDR0) ? WAIT_H1 : IDLE;
                WAIT_H1: nxt = (uart_data == HDR1) ? CMD : (uart_data == HDR0) ? WAIT_H1 : IDLE;
                CMD:     nxt = LEN;
                LEN:     nxt = len_bad ? IDLE : (uart_data == 8'd0) ? CHK : PAYLOAD;
                PAYLOAD: nxt = last ? CHK : PAYLOAD;
                CHK:     nxt = IDLE;
                default: nxt = IDLE;
            endcase
        end else if (expire) begin
            nxt = IDLE;
        end
    end

    always_comb begin
        good    = byte_stb && state == CHK && uart_data == sum;
        bad_chk = byte_stb && state == CHK && uart_data != sum;
        bad_len = byte_stb && state == LEN && len_bad;
        tmo     = !byte_stb && expire;
        wr      = byte_stb && state == PAYLOAD;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            uart_done_d <= 1'b0;
            sum         <= '0;
            cmd_r       <= '0;
            len         <= '0;
            idx         <= '0;
            cnt         <= '0;
            frame_valid <= 1'b0;
            err_chk     <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            frame_cmd   <= '0;
            frame_len   <= '0;
            rd_data     <= '0;
        end else begin
            uart_done_d <= uart_done;
            frame_valid <= good;
            err_chk     <= bad_chk;
            err_len     <= bad_len;
            err_timeout <= tmo;
            // Counter saturates at the expiry value instead of wrapping.
            cnt <= (byte_stb || state == IDLE) ? '0 : (cnt == CW'(TO_CYC)) ? cnt : cnt + 1'b1;
            if (byte_stb) begin
                case (state)
                    CMD: begin
                        cmd_r <= uart_data;
                        sum   <= uart_data;
                    end
                    LEN: begin
                        sum <= sum + uart_data;
                        len <= uart_data[ADDR_W:0];
                        idx <= '0;
                    end
                    PAYLOAD: begin
                        sum <= sum + uart_data;
                        idx <= idx + 1'b1;
                    end
                    default: ;
                endcase
            end
            if (good) begin
                frame_cmd <= cmd_r;
                frame_len <= len;
            end
            rd_data <= (32'(rd_addr) < MAX_LEN) ? mem[rd_addr] : 8'h00;
        end
    end

    // Buffer RAM is intentionally not reset.
    always_ff @(posedge sys_clk)
        if (wr) mem[idx] <= uart_data;
endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser: randomized scoreboard bench for uart_frame_parser
module tb_uart_frame_parser;
    localparam int TO_CYC = 3000;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       uart_done = 1'b0;
    logic [7:0] uart_data = 8'h00;
    logic [3:0] rd_addr = 4'd0;
    logic [7:0] rd_data;
    logic       frame_valid, busy, err_chk, err_len, err_timeout;
    logic [7:0] frame_cmd;
    logic [4:0] frame_len;

    uart_frame_parser #(.CLK_FREQ(1000000), .TIMEOUT_US(TO_CYC), .MAX_LEN(16), .ADDR_W(4)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_done(uart_done), .uart_data(uart_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .frame_valid(frame_valid), .frame_cmd(frame_cmd),
        .frame_len(frame_len), .busy(busy), .err_chk(err_chk), .err_len(err_len),
        .err_timeout(err_timeout)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [1:0]   kind;
        logic [7:0]   cmd;
        logic [4:0]   len;
        logic [127:0] pl;
    } ev_t;

    ev_t        q[$];
    logic [7:0] tx[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_cmd = 8'h00;
    logic [4:0] exp_len = 5'd0;

    task automatic check(input string n, input logic [31:0] a, input logic [31:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", n, a, x);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        uart_data = b;
        uart_done = 1'b1;
        repeat (hold) @(negedge sys_clk);
        uart_done = 1'b0;
        uart_data = 8'($urandom);
        repeat ($urandom_range(1, 3)) @(negedge sys_clk);
    endtask

    task automatic send_tx(input int long_idx);
        for (int i = 0; i < tx.size(); i++)
            send_byte(tx[i], (i == long_idx) ? 2000 : $urandom_range(1, 3));
        tx.delete();
    endtask

    task automatic noise(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            if (b == 8'h55) b = 8'h00;
            tx.push_back(b);
        end
        send_tx(-1);
    endtask

    task automatic frame(input logic [7:0] cmd, input int len, input logic [127:0] pl,
                         input logic [7:0] delta, input int pre55, input int long_idx);
        ev_t e;
        logic [7:0] s;
        s = cmd + 8'(len);
        repeat (pre55) tx.push_back(8'h55);
        tx.push_back(8'h55);
        tx.push_back(8'hAA);
        tx.push_back(cmd);
        tx.push_back(8'(len));
        for (int i = 0; i < len; i++) begin
            tx.push_back(pl[i*8+:8]);
            s += pl[i*8+:8];
        end
        tx.push_back(s + delta);
        if (delta == 8'h00) begin
            exp_cmd = cmd;
            exp_len = 5'(len);
        end
        e.kind = (delta == 8'h00) ? 2'd0 : 2'd1;
        e.cmd  = exp_cmd;
        e.len  = exp_len;
        e.pl   = pl;
        q.push_back(e);
        send_tx(long_idx);
        repeat (20) @(negedge sys_clk);
    endtask

    task automatic len_err(input logic [7:0] cmd, input logic [7:0] l);
        ev_t e;
        e = '{kind: 2'd2, cmd: exp_cmd, len: exp_len, pl: '0};
        q.push_back(e);
        tx = '{8'h55, 8'hAA, cmd, l};
        send_tx(-1);
        repeat (20) @(negedge sys_clk);
    endtask

    task automatic timeout(input logic [7:0] cmd);
        ev_t e;
        e = '{kind: 2'd3, cmd: exp_cmd, len: exp_len, pl: '0};
        q.push_back(e);
        tx = '{8'h55, 8'hAA, cmd};
        send_tx(-1);
        check("busy_mid_frame", 32'(busy), 32'd1);
        repeat (TO_CYC + 20) @(negedge sys_clk);
        check("busy_after_timeout", 32'(busy), 32'd0);
    endtask

    function automatic logic [127:0] rnd_pl();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        ev_t  e;
        logic [1:0] got;
        forever begin
            @(negedge sys_clk);
            if (sys_rst_n && (frame_valid | err_chk | err_len | err_timeout)) begin
                got = frame_valid ? 2'd0 : err_chk ? 2'd1 : err_len ? 2'd2 : 2'd3;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got kind %0d, required no pulse", got);
                end else begin
                    e = q.pop_front();
                    check("pulse_onehot", 32'($countones({frame_valid, err_chk, err_len, err_timeout})), 32'd1);
                    check("pulse_kind", 32'(got), 32'(e.kind));
                    check("frame_cmd", 32'(frame_cmd), 32'(e.cmd));
                    check("frame_len", 32'(frame_len), 32'(e.len));
                    if (got == 2'd0 && e.kind == 2'd0)
                        for (int i = 0; i < 32'(e.len); i++) begin
                            rd_addr = 4'(i);
                            @(negedge sys_clk);
                            check("payload", 32'(rd_data), 32'(e.pl[i*8+:8]));
                        end
                end
            end
        end
    end

    initial begin
        int r;
        #2;
        check("rst_outputs", {frame_valid, err_chk, err_len, err_timeout, busy, frame_cmd, frame_len, rd_data}, 32'd0);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        frame(8'h10, 3, 128'h030201, 8'h00, 0, -1);
        frame(8'h10, 1, 128'hFF, 8'hF0, 0, -1);
        len_err(8'h20, 8'h11);
        frame(8'h20, 0, 128'h0, 8'h00, 0, -1);
        frame(8'h01, 0, 128'h0, 8'h00, 1, -1);
        timeout(8'h05);
        frame(8'h33, 16, rnd_pl(), 8'h00, 0, -1);
        frame(8'h44, 2, rnd_pl(), 8'h00, 0, 4);

        tx = '{8'h55, 8'hAA, 8'h10};
        send_tx(-1);
        sys_rst_n = 1'b0;
        #1;
        check("midframe_rst", {frame_valid, err_chk, err_len, err_timeout, busy, frame_cmd, frame_len, rd_data}, 32'd0);
        exp_cmd = 8'h00;
        exp_len = 5'd0;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        frame(8'h5A, 5, rnd_pl(), 8'h00, 0, 2);

        for (int k = 0; k < 40; k++) begin
            noise($urandom_range(0, 3));
            r = $urandom_range(0, 9);
            if (r < 6)
                frame(8'($urandom), $urandom_range(0, 16), rnd_pl(), 8'h00, $urandom_range(0, 2), -1);
            else if (r < 8)
                frame(8'($urandom), $urandom_range(0, 16), rnd_pl(), 8'($urandom_range(1, 255)), 0, -1);
            else if (r < 9)
                len_err(8'($urandom), 8'($urandom_range(17, 255)));
            else
                timeout(8'($urandom));
        end

        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge sys_clk);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
